// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
// mdu_iter : iterative RV32M multiply/divide unit (shift-add / restoring div)
// Rev 1.0
// ============================================================================
module mdu_iter #(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [2:0]      i_op,
   input  logic [XLEN-1:0] i_op1,
   input  logic [XLEN-1:0] i_op2,
   output logic            o_valid,
   output logic [XLEN-1:0] o_result,
   output logic            o_busy
);

   localparam int CW = $clog2(XLEN) + 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   logic [1:0]        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2:0]        op_q, op_d;
   logic              s1_q, s1_d;
   logic              s2_q, s2_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [2*XLEN-1:0] a_q, a_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic              valid_q, valid_d;

   logic              w_sgn1, w_sgn2;
   logic [XLEN-1:0]   w_mag1, w_mag2;
   logic [XLEN:0]     w_rem_sh;
   logic              w_qbit;
   logic [2*XLEN-1:0] w_prod;
   logic [XLEN-1:0]   w_quot, w_rem;

   always_comb begin
      w_sgn1 = 1'b0;
      w_sgn2 = 1'b0;
      case (i_op)
         OP_MULH, OP_DIV, OP_REM: begin
            w_sgn1 = i_op1[XLEN-1];
            w_sgn2 = i_op2[XLEN-1];
         end
         OP_MULHSU: w_sgn1 = i_op1[XLEN-1];
         default: ;
      endcase
      // Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
      w_mag1 = w_sgn1 ? (~i_op1 + 1'b1) : i_op1;
      w_mag2 = w_sgn2 ? (~i_op2 + 1'b1) : i_op2;
   end

   always_comb begin
      w_rem_sh = {acc_q[XLEN-1:0], a_q[XLEN-1]};
      w_qbit   = (w_rem_sh >= {1'b0, b_q});
      w_prod   = (s1_q ^ s2_q) ? (~acc_q + 1'b1) : acc_q;
      w_quot   = a_q[XLEN-1:0];
      w_rem    = acc_q[XLEN-1:0];
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      s1_d     = s1_q;
      s2_d     = s2_q;
      acc_d    = acc_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      valid_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (i_valid) begin
               state_d = ST_CALC;
               cnt_d   = '0;
               op_d    = i_op;
               s1_d    = w_sgn1;
               s2_d    = w_sgn2;
               acc_d   = '0;
               a_d     = {{XLEN{1'b0}}, w_mag1};
               b_d     = w_mag2;
            end
         end

         ST_CALC: begin
            if (cnt_q == CW'(XLEN)) begin
               state_d = ST_DONE;
               valid_d = 1'b1;
               case (op_q)
                  OP_MUL:                      result_d = w_prod[XLEN-1:0];
                  OP_MULH, OP_MULHSU, OP_MULHU: result_d = w_prod[2*XLEN-1:XLEN];
                  OP_DIV:  result_d = (b_q == '0) ? {XLEN{1'b1}}
                                    : ((s1_q ^ s2_q) ? (~w_quot + 1'b1) : w_quot);
                  OP_DIVU: result_d = (b_q == '0) ? {XLEN{1'b1}} : w_quot;
                  // Zero divisor leaves |op1| in the remainder, so re-signing restores op1.
                  OP_REM:  result_d = s1_q ? (~w_rem + 1'b1) : w_rem;
                  default: result_d = w_rem;
               endcase
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (op_q[2]) begin
                  acc_d = {{(XLEN-1){1'b0}}, (w_qbit ? (w_rem_sh - {1'b0, b_q}) : w_rem_sh)};
                  a_d   = {{XLEN{1'b0}}, a_q[XLEN-2:0], w_qbit};
               end else begin
                  if (b_q[0]) begin
                     acc_d = acc_q + a_q;
                  end
                  a_d = {a_q[2*XLEN-2:0], 1'b0};
                  b_d = {1'b0, b_q[XLEN-1:1]};
               end
            end
         end

         ST_DONE: state_d = ST_IDLE;

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         acc_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         acc_q    <= acc_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         valid_q  <= valid_d;
      end
   end

   assign o_ready  = (state_q == ST_IDLE);
   assign o_busy   = (state_q != ST_IDLE);
   assign o_valid  = valid_q;
   assign o_result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// ============================================================================
// tb_mdu_iter : scoreboard bench for mdu_iter with directed RV32M vectors
// Rev 1.0
// ============================================================================
module tb_mdu_iter;

   logic        clk;
   logic        rst;
   logic        i_valid;
   logic        o_ready;
   logic [2:0]  i_op;
   logic [31:0] i_op1;
   logic [31:0] i_op2;
   logic        o_valid;
   logic [31:0] o_result;
   logic        o_busy;

   mdu_iter #(.XLEN(32)) dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_valid  (i_valid),
      .o_ready  (o_ready),
      .i_op     (i_op),
      .i_op1    (i_op1),
      .i_op2    (i_op2),
      .o_valid  (o_valid),
      .o_result (o_result),
      .o_busy   (o_busy)
   );

   typedef struct {
      logic [31:0] res;
      int          when;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: pops one expectation per o_valid pulse and checks value and cycle.
   always @(negedge clk) begin
      if (o_valid && o_ready) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL valid_ready_overlap at cycle %0d", cyc);
      end
      if (o_valid) begin
         checks = checks + 1;
         if (sb.size() == 0) begin
            errors = errors + 1;
            $display("FAIL unexpected_valid at cycle %0d result %h", cyc, o_result);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (o_result !== e.res || cyc != e.when) begin
               errors = errors + 1;
               $display("FAIL %s: got %h at cycle %0d, expected %h at cycle %0d",
                        e.name, o_result, cyc, e.res, e.when);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Drives a request, waits (bounded) for acceptance and records the accept edge.
   task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string nm, output int t);
      int n;
      exp_t e;
      i_valid = 1'b1;
      i_op    = op;
      i_op1   = a;
      i_op2   = b;
      n = 0;
      while (!o_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!o_ready) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL %s accept_timeout: o_ready %b expected 1", nm, o_ready);
         t = -1;
      end else begin
         @(posedge clk);
         #1;
         t = cyc;
         e.res  = exp;
         e.when = t + 33;
         e.name = nm;
         sb.push_back(e);
      end
   endtask

   initial begin
      int t, t2, n;
      rst     = 1'b0;
      i_valid = 1'b0;
      i_op    = 3'd0;
      i_op1   = 32'd0;
      i_op2   = 32'd0;
      repeat (3) @(negedge clk);
      chk("reset_ready",  {31'd0, o_ready}, 32'd1);
      chk("reset_valid",  {31'd0, o_valid}, 32'd0);
      chk("reset_busy",   {31'd0, o_busy},  32'd0);
      chk("reset_result", o_result,         32'd0);
      rst = 1'b1;
      @(negedge clk);

      // First MUL with a cycle-by-cycle ready/busy timeline.
      send(3'd0, 32'd7, 32'd6, 32'd42, "mul_7x6", t);
      i_valid = 1'b0;
      i_op1   = 32'hDEAD_BEEF;
      do begin
         @(negedge clk);
         chk("ready_timeline", {31'd0, o_ready}, {31'd0, (cyc >= t + 34)});
         chk("busy_timeline",  {31'd0, o_busy},  {31'd0, (cyc <  t + 34)});
      end while (cyc < t + 35);

      send(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_m1_m1", t);
      send(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max", t);
      send(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, "mulhsu_m1_2", t);
      send(3'd0, 32'h8000_0000, 32'h0000_0002, 32'h0000_0000, "mul_wrap", t);
      send(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_m7_2", t);
      send(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_m7_2", t);
      send(3'd4, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, "div_20_m3", t);
      send(3'd6, 32'd20, 32'hFFFF_FFFD, 32'h0000_0002, "rem_20_m3", t);
      send(3'd5, 32'hFFFF_FFFE, 32'd2, 32'h7FFF_FFFF, "divu_big_2", t);
      send(3'd7, 32'd100, 32'd7, 32'd2, "remu_100_7", t);
      send(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, "div_by_zero", t);
      send(3'd7, 32'd5, 32'd0, 32'd5, "remu_by_zero", t);
      send(3'd6, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, "rem_by_zero", t);
      send(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_overflow", t);
      send(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_overflow", t);

      // Back-to-back: i_valid held high with new operands while busy.
      send(3'd0, 32'd3, 32'd5, 32'd15, "b2b_first", t);
      send(3'd0, 32'h10, 32'h10, 32'h100, "b2b_second", t2);
      i_valid = 1'b0;
      chk("b2b_accept_edge", t2, t + 35);

      // Reset asserted mid-computation aborts it.
      send(3'd5, 32'd100, 32'd7, 32'd14, "aborted", t);
      i_valid = 1'b0;
      while (cyc < t + 10) @(negedge clk);
      rst = 1'b0;
      void'(sb.pop_back());
      @(negedge clk);
      chk("abort_valid",  {31'd0, o_valid}, 32'd0);
      chk("abort_result", o_result,         32'd0);
      chk("abort_ready",  {31'd0, o_ready}, 32'd1);
      chk("abort_busy",   {31'd0, o_busy},  32'd0);
      rst = 1'b1;
      repeat (40) @(negedge clk);
      send(3'd5, 32'd9, 32'd3, 32'd3, "divu_after_reset", t);
      i_valid = 1'b0;

      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
      end
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit implementing the RV32M operations for the single-cycle core.
- Sits beside the ALU, directly downstream of the register file. Consumes rs1/rs2 read data and produces a result for rd write-back.
- The core stalls while the unit is busy and writes o_result to the register file on the o_valid pulse.
- Uses a shift-add multiplier and a restoring divider: one bit per cycle, 32 iterations.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported; the iteration counter is $clog2(XLEN)+1 bits.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  synchronous, active-low reset.
- i_valid  input  1  request strobe; the request is accepted on an edge where i_valid && o_ready.
- o_ready  output  1  high only in IDLE.
- i_op  input  3  RISC-V funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- i_op1  input  XLEN  rs1 data (multiplicand / dividend).
- i_op2  input  XLEN  rs2 data (multiplier / divisor).
- o_valid  output  1  one-cycle pulse; o_result is valid while it is high.
- o_result  output  XLEN  result.
- o_busy  output  1  high in CALC and DONE.

Behaviour:
- Reset (i_rst==0 at an edge):
  - State goes to IDLE; o_valid=0, o_result=0, o_ready=1 (IDLE), o_busy=0.
  - The iteration counter and operand registers clear to 0.
  - Reset overrides every other input, including a reset asserted mid-operation: the computation is aborted, no o_valid is produced, and the first request after reset releases computes normally.
- States:
  - IDLE -> CALC on accept.
  - CALC -> DONE after exactly 32 iterations.
  - DONE -> IDLE unconditionally after one cycle.
- Accept edge:
  - Latch i_op, i_op1 and i_op2; inputs may change freely afterwards.
  - Record sign flags and convert signed operands to magnitudes:
    - MULH: both operands signed.
    - MULHSU: op1 signed, op2 unsigned.
    - DIV/REM: both signed.
    - MUL: treated as unsigned; the low 32 bits are sign-agnostic.
- Latency (accept on edge t):
  - o_valid=1 only in the cycle after edge t+33.
  - o_ready returns to 1 after edge t+34.
  - Latency is fixed for every op and operand value, including the special cases below.
- Requests while busy: i_valid is ignored while o_ready=0; no queueing. The core holds i_valid until accepted.
- o_result holds its last value between pulses. It changes only at the edge entering DONE (or at reset).
- Multiply:
  - 64-bit shift-add of the magnitudes; negate the 64-bit product if the sign flags differ.
  - MUL returns bits [31:0]; MULH/MULHSU/MULHU return bits [63:32].
- Divide:
  - Restoring division of the magnitudes, one quotient bit per iteration (MSB first), with a 33-bit partial remainder.
  - Quotient sign = sign(op1) XOR sign(op2); remainder takes the sign of op1.
- Special cases, resolved at DONE but with the same latency:
  - Divisor 0: DIV/DIVU = 0xFFFFFFFF; REM/REMU = op1.
  - Signed overflow (op1=0x80000000, op2=0xFFFFFFFF): DIV = 0x80000000, REM = 0.
- Magnitude of 0x80000000 is 0x80000000 held unsigned; no overflow occurs in the magnitude path.
- o_valid and o_ready are never both high in the same cycle.

Test Plan:
- Reset, then MUL 7 x 6: accept at edge t -> o_valid exactly one cycle after edge t+33, o_result=42. o_ready=0 from t+1 to t+34, then 1.
- MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000. MULHU same operands -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF. MUL 0x80000000 x 2 -> 0.
- DIV -7 / 2 -> 0xFFFFFFFD (-3). REM -7 / 2 -> 0xFFFFFFFF (-1). DIVU 0xFFFFFFFE / 2 -> 0x7FFFFFFF. REMU 100 / 7 -> 2.
- Divisor 0: DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0. Each still takes 33 cycles.
- i_valid held high with new operands during CALC -> no second accept until o_ready=1. The back-to-back second request is accepted at edge t+35; i_op1 changed after accept does not affect the first result.
- i_rst=0 at the 10th CALC cycle -> next cycle state IDLE, o_valid=0, o_result=0, o_ready=1. No o_valid pulse follows; the next request (DIVU 9/3) returns 3.
